tone_player: RTL and testbench

Parametrised square-wave tone player that supersedes the fixed-frequency free-running beep. Accepts queued note commands (half-period, duration) over a valid/ready handshake, buffers them in a small FIFO and plays them in order on SPEAKER. Each note is followed by a silent articulation gap, and a completion pulse is raised per note. Sits between a melody source (ROM walker or host logic) and the speaker pin.

---
 rtl/tone_player_pkg.sv | 32 +++
 rtl/tone_player_note_fifo.sv | 75 +++++++
 rtl/tone_player.sv | 167 ++++++++++++++++
 tb/tb_tone_player.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_player_pkg.sv
// Shared definitions for the tone player: FSM state encoding and the
// elaboration-time helpers used to size counters from clock parameters.
package tone_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Ceiling log2, valid for value >= 1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    // Clock cycles in one millisecond.
    function automatic int ms_cycles(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    // Bits needed to count 0..count-1, never less than one bit.
    function automatic int cnt_width(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

endpackage

// File: rtl/tone_player_note_fifo.sv
// note_fifo: synchronous FIFO holding queued note commands.
// Ports:
//   clk, rst       clock and synchronous active-high reset (flushes the queue)
//   push, wdata    write request and data; ignored while full
//   pop            read request; ignored while empty
//   rdata          head entry (valid while !empty), no fall-through
//   full, empty    occupancy flags
module note_fifo
    import tone_player_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; the flush is done by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/tone_player.sv
// tone_player: queued square-wave note player.
// Ports:
//   CLK, RST       clock and synchronous active-high reset
//   NOTE_VALID     note command offered; accepted when NOTE_READY is high
//   NOTE_READY     queue has room (independent of NOTE_VALID)
//   NOTE_HALFPER   half-period in CLK cycles, 0 = rest
//   NOTE_DUR       duration in ms, 0 = skip the note
//   ENABLE         0 freezes all timing and silences SPEAKER
//   SPEAKER        square-wave output
//   BUSY           a note is in progress or the queue is non-empty
//   NOTE_DONE      one-cycle pulse when a note and its gap have finished
module tone_player
    import tone_player_pkg::*;
#(
    parameter int CLK_HZ     = 16000000,
    parameter int DIV_W      = 16,
    parameter int DUR_W      = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_MS     = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             NOTE_VALID,
    output logic             NOTE_READY,
    input  logic [DIV_W-1:0] NOTE_HALFPER,
    input  logic [DUR_W-1:0] NOTE_DUR,
    input  logic             ENABLE,
    output logic             SPEAKER,
    output logic             BUSY,
    output logic             NOTE_DONE
);

    localparam int MS_CYCLES = ms_cycles(CLK_HZ);
    localparam int PRE_W     = cnt_width(MS_CYCLES);
    localparam int GAP_CYC   = GAP_MS * MS_CYCLES;
    localparam int GAP_W     = cnt_width(GAP_CYC);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    logic                   fifo_full, fifo_empty, fifo_pop;
    logic [DIV_W+DUR_W-1:0] fifo_rdata;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   hp_q, hp_d;
    logic [DUR_W-1:0]   dur_q, dur_d;     // remaining ms while playing
    logic [DIV_W-1:0]   tone_q, tone_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               spk_q, spk_d;
    logic               done_q, done_d;

    assign fifo_pop = ENABLE && (state_q == ST_IDLE) && !fifo_empty;

    note_fifo #(
        .WIDTH (DIV_W + DUR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (NOTE_VALID),
        .pop   (fifo_pop),
        .wdata ({NOTE_HALFPER, NOTE_DUR}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        dur_d   = dur_q;
        tone_d  = tone_q;
        pre_d   = pre_q;
        gap_d   = gap_q;
        spk_d   = spk_q;
        done_d  = 1'b0;
        // With ENABLE low everything holds; only the outputs are gated.
        if (ENABLE) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        hp_d    = fifo_rdata[DUR_W +: DIV_W];
                        dur_d   = fifo_rdata[0 +: DUR_W];
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (dur_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tone_d  = '0;
                        pre_d   = '0;
                        spk_d   = 1'b0;
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (hp_q != '0) begin
                        if (tone_q == hp_q - DIV_W'(1)) begin
                            tone_d = '0;
                            spk_d  = !spk_q;
                        end else begin
                            tone_d = tone_q + DIV_W'(1);
                        end
                    end
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        dur_d = dur_q - DUR_W'(1);
                        // Last cycle of the last ms: leave PLAY silenced.
                        if (dur_q == DUR_W'(1)) begin
                            spk_d  = 1'b0;
                            tone_d = '0;
                            if (GAP_CYC == 0) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                gap_d   = '0;
                                state_d = ST_GAP;
                            end
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            tone_q  <= '0;
            pre_q   <= '0;
            gap_q   <= '0;
            spk_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            pre_q   <= pre_d;
            gap_q   <= gap_d;
            spk_q   <= spk_d;
            done_q  <= done_d;
        end
        hp_q  <= hp_d;
        dur_q <= dur_d;
    end

    // Outputs are forced low for the whole time RST is asserted, not just
    // after the first reset edge. done_q keeps BUSY high through the
    // NOTE_DONE cycle so it falls the cycle after.
    assign NOTE_READY = !RST && !fifo_full;
    assign SPEAKER    = !RST && ENABLE && spk_q;
    assign NOTE_DONE  = !RST && done_q;
    assign BUSY       = !RST && ((state_q != ST_IDLE) || !fifo_empty || done_q);

endmodule

// File: tb/tb_tone_player.sv
module tb_tone_player;

    localparam int CLK_HZ     = 16000;
    localparam int DIV_W      = 16;
    localparam int DUR_W      = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_MS     = 1;
    localparam int MS         = CLK_HZ / 1000;
    localparam int GAP_CYC    = GAP_MS * MS;

    logic             clk = 1'b0;
    logic             rst;
    logic             note_valid;
    logic             note_ready;
    logic [DIV_W-1:0] note_halfper;
    logic [DUR_W-1:0] note_dur;
    logic             enable;
    logic             speaker;
    logic             busy;
    logic             note_done;

    always #5 clk = ~clk;

    tone_player #(
        .CLK_HZ     (CLK_HZ),
        .DIV_W      (DIV_W),
        .DUR_W      (DUR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_MS     (GAP_MS)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .NOTE_VALID   (note_valid),
        .NOTE_READY   (note_ready),
        .NOTE_HALFPER (note_halfper),
        .NOTE_DUR     (note_dur),
        .ENABLE       (enable),
        .SPEAKER      (speaker),
        .BUSY         (busy),
        .NOTE_DONE    (note_done)
    );

    // Reference model: a queue of accepted notes plus a per-enabled-cycle
    // plan of expected {speaker phase, done} values for the note in flight.
    typedef struct packed { logic spk; logic done; } ent_t;
    typedef struct { int hp; int dur; } note_t;

    note_t mq[$];
    ent_t  plan[$];
    logic  m_spk, m_done, m_pushed;
    int    checks, errors;

    task automatic build_plan(input int hp, input int dur);
        ent_t e;
        if (dur == 0) begin
            e.spk = 1'b0; e.done = 1'b1; plan.push_back(e);
        end else begin
            for (int k = 0; k < dur * MS; k++) begin
                e.spk  = (hp == 0) ? 1'b0 : (((k / hp) % 2) == 1);
                e.done = 1'b0;
                plan.push_back(e);
            end
            for (int g = 0; g < GAP_CYC; g++) begin
                e.spk = 1'b0; e.done = 1'b0; plan.push_back(e);
            end
            e.spk = 1'b0; e.done = 1'b1; plan.push_back(e);
        end
    endtask

    task automatic model_step();
        ent_t  e;
        note_t n;
        logic  can_push;
        m_pushed = 1'b0;
        if (rst) begin
            mq.delete(); plan.delete(); m_spk = 1'b0; m_done = 1'b0;
            return;
        end
        can_push = note_valid && (mq.size() < FIFO_DEPTH);
        if (!enable) begin
            m_done = 1'b0;
        end else if (plan.size() > 0) begin
            e = plan.pop_front(); m_spk = e.spk; m_done = e.done;
        end else if (mq.size() > 0) begin
            n = mq.pop_front(); build_plan(n.hp, n.dur);
            m_spk = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
        end
        if (can_push) begin
            n.hp = int'(note_halfper); n.dur = int'(note_dur);
            mq.push_back(n); m_pushed = 1'b1;
        end
    endtask

    // Expected {SPEAKER, NOTE_DONE, BUSY, NOTE_READY} for the current cycle.
    function automatic logic [3:0] exp_vec();
        if (rst) return 4'b0000;
        return {m_spk && enable, m_done,
                (plan.size() > 0) || (mq.size() > 0) || m_done,
                mq.size() < FIFO_DEPTH};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input int hp, input int dur);
        note_valid   = v;
        note_halfper = DIV_W'(hp);
        note_dur     = DUR_W'(dur);
    endtask

    task automatic test_reset();
        logic [3:0] want;
        rst = 1'b1; enable = 1'b1; drive(1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({speaker, note_done, busy, note_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold got=%b want=0000", {speaker, note_done, busy, note_ready});
            end
        end
        rst = 1'b0;
        #1;
        want = exp_vec();
        checks++;
        if ({speaker, note_done, busy, note_ready} !== 4'b0001 || want !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release got=%b want=0001", {speaker, note_done, busy, note_ready});
        end
    endtask

    task automatic test_single_note();
        int cyc, rises, done_at;
        logic prev;
        drive(1'b1, 4, 2); tick(); drive(1'b0, 0, 0);
        cyc = 0; rises = 0; done_at = 0; prev = 1'b0;
        for (int i = 0; i < 120 && done_at == 0; i++) begin
            tick(); cyc++;
            checks++;
            if ({speaker, note_done, busy, note_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL single_trace cyc=%0d got=%b want=%b", cyc, {speaker, note_done, busy, note_ready}, exp_vec());
            end
            if (speaker && !prev) rises++;
            prev = speaker;
            if (note_done) done_at = cyc;
        end
        checks++;
        if (done_at != 50) begin
            errors++; $display("FAIL single_done_latency got=%0d want=50", done_at);
        end
        checks++;
        if (rises != 4) begin
            errors++; $display("FAIL single_rising_edges got=%0d want=4", rises);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || note_done !== 1'b0) begin
            errors++; $display("FAIL single_busy_drop got=%b%b want=00", busy, note_done);
        end
    endtask

    task automatic test_queue_full();
        int hps[5];
        int idx, acc_edge, dones;
        logic rb;
        hps = '{2, 3, 4, 5, 6};
        enable = 1'b0; idx = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, hps[idx], 1);
            rb = note_ready;
            tick();
            checks++;
            if ({speaker, note_done, busy, note_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL full_fill got=%b want=%b", {speaker, note_done, busy, note_ready}, exp_vec());
            end
            if (rb && idx < 4) idx++;
        end
        checks++;
        if (idx != 4 || note_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready accepted=%0d ready=%b want 4 and 0", idx, note_ready);
        end
        enable = 1'b1; acc_edge = 0;
        for (int k = 0; k < 10 && acc_edge == 0; k++) begin
            rb = note_ready;
            tick();
            checks++;
            if ({speaker, note_done, busy, note_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL full_fifth got=%b want=%b", {speaker, note_done, busy, note_ready}, exp_vec());
            end
            if (rb) acc_edge = k + 1;
        end
        drive(1'b0, 0, 0);
        checks++;
        if (acc_edge != 2) begin
            errors++; $display("FAIL full_fifth_accept edge got=%0d want=2", acc_edge);
        end
        dones = 0;
        for (int i = 0; i < 600 && dones < 5; i++) begin
            tick();
            checks++;
            if ({speaker, note_done, busy, note_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL full_play got=%b want=%b", {speaker, note_done, busy, note_ready}, exp_vec());
            end
            if (note_done) dones++;
        end
        checks++;
        if (dones != 5) begin
            errors++; $display("FAIL full_done_count got=%0d want=5", dones);
        end
    endtask

    task automatic test_rest();
        int cyc, done_at;
        logic heard;
        drive(1'b1, 0, 3); tick(); drive(1'b0, 0, 0);
        cyc = 0; done_at = 0; heard = 1'b0;
        for (int i = 0; i < 150 && done_at == 0; i++) begin
            tick(); cyc++;
            checks++;
            if ({speaker, note_done, busy, note_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL rest_trace cyc=%0d got=%b want=%b", cyc, {speaker, note_done, busy, note_ready}, exp_vec());
            end
            if (speaker) heard = 1'b1;
            if (note_done) done_at = cyc;
        end
        checks++;
        if (done_at != 66 || heard) begin
            errors++; $display("FAIL rest_timing done=%0d heard=%b want 66 and 0", done_at, heard);
        end
    endtask

    task automatic test_dur_zero();
        int cyc, d1, d2;
        logic heard;
        drive(1'b1, 7, 0); tick();
        drive(1'b1, 3, 1); tick(); drive(1'b0, 0, 0);
        cyc = 1; d1 = 0; d2 = 0; heard = 1'b0;
        for (int i = 0; i < 120 && d2 == 0; i++) begin
            tick(); cyc++;
            checks++;
            if ({speaker, note_done, busy, note_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL zero_trace cyc=%0d got=%b want=%b", cyc, {speaker, note_done, busy, note_ready}, exp_vec());
            end
            if (speaker && d1 == 0) heard = 1'b1;
            if (note_done) begin
                if (d1 == 0) d1 = cyc; else d2 = cyc;
            end
        end
        checks++;
        if (d1 != 2 || d2 != 36 || heard) begin
            errors++; $display("FAIL zero_timing d1=%0d d2=%0d heard=%b want 2 36 0", d1, d2, heard);
        end
    endtask

    task automatic test_pause();
        int cyc, done_at;
        drive(1'b1, 4, 2); tick(); drive(1'b0, 0, 0);
        cyc = 0; done_at = 0;
        for (int i = 0; i < 150 && done_at == 0; i++) begin
            enable = !(cyc >= 12 && cyc < 22);
            tick(); cyc++;
            checks++;
            if ({speaker, note_done, busy, note_ready} !== exp_vec() || (!enable && speaker !== 1'b0)) begin
                errors++;
                $display("FAIL pause_trace cyc=%0d got=%b want=%b", cyc, {speaker, note_done, busy, note_ready}, exp_vec());
            end
            if (note_done) done_at = cyc;
        end
        enable = 1'b1;
        checks++;
        if (done_at != 60) begin
            errors++; $display("FAIL pause_done_latency got=%0d want=60", done_at);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        drive(1'b1, 5, 3); tick();
        drive(1'b1, 6, 2); tick();
        drive(1'b1, 2, 1); tick();
        drive(1'b0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({speaker, note_done, busy, note_ready} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_assert got=%b want=0000", {speaker, note_done, busy, note_ready});
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({speaker, note_done, busy, note_ready} !== 4'b0001) begin
            errors++; $display("FAIL rstmid_release got=%b want=0001", {speaker, note_done, busy, note_ready});
        end
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({speaker, note_done, busy, note_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_after got=%b want=%b", {speaker, note_done, busy, note_ready}, exp_vec());
            end
            if (note_done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL rstmid_no_done got=%0d want=0", dones);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
            tick();
            checks++;
            if ({speaker, note_done, busy, note_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL random_trace i=%0d got=%b want=%b", i, {speaker, note_done, busy, note_ready}, exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_spk = 1'b0; m_done = 1'b0; m_pushed = 1'b0;
        rst = 1'b1; enable = 1'b1;
        note_valid = 1'b0; note_halfper = '0; note_dur = '0;
        test_reset();
        test_single_note();
        test_queue_full();
        test_rest();
        test_dur_zero();
        test_pause();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
